// File: rtl/kalman_seq_pkg.sv
// Shared types and constants for the Kalman-filter CMU sequencers.
// Double-precision constants are raw IEEE-754 bit patterns.
`timescale 1ns/1ps
package kalman_seq_pkg;

    localparam int DBL_WIDTH_DFLT = 64;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WRITE,
        DONE
    } seq_state_t;

    localparam logic [63:0] ZERO    = 64'h0000000000000000;
    localparam logic [63:0] QUARTER = 64'h3FD0000000000000;
    localparam logic [63:0] HALF    = 64'h3FE0000000000000;
    localparam logic [63:0] ONE     = 64'h3FF0000000000000;
    localparam logic [63:0] TWO     = 64'h4000000000000000;

endpackage

// File: rtl/cmu_watchdog.sv
// Counts enabled cycles since the last clear; expire flags the TIMEOUT-th enabled cycle.
// The count saturates so a stalled enable never wraps back to a quiet state.
`timescale 1ns/1ps
module cmu_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/cmu_phi_sequencer.sv
// Walks the element list, fetches Theta/Q operands, drives one CMU through its
// valid/finish handshake and writes each result back; aborts on watchdog expiry.
`timescale 1ns/1ps
module cmu_phi_sequencer
    import kalman_seq_pkg::*;
#(
    parameter int DBL_WIDTH = DBL_WIDTH_DFLT,
    parameter int N_ELEM    = 16,
    parameter int IDX_W     = $clog2(N_ELEM),
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IDX_W:0]       n_elem,
    input  logic [DBL_WIDTH-1:0] delta_t,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 rd_en,
    output logic [IDX_W-1:0]     rd_addr,
    input  logic [DBL_WIDTH-1:0] rd_theta_a,
    input  logic [DBL_WIDTH-1:0] rd_theta_b,
    input  logic [DBL_WIDTH-1:0] rd_q,
    output logic                 cmu_valid,
    output logic [DBL_WIDTH-1:0] cmu_x,
    output logic [DBL_WIDTH-1:0] cmu_y,
    output logic [DBL_WIDTH-1:0] cmu_q,
    output logic [DBL_WIDTH-1:0] cmu_dt,
    input  logic                 cmu_finish,
    input  logic [DBL_WIDTH-1:0] cmu_result,
    output logic                 wr_en,
    output logic [IDX_W-1:0]     wr_addr,
    output logic [DBL_WIDTH-1:0] wr_data
);
    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(N_ELEM);

    seq_state_t           state_q;
    logic [IDX_W:0]       cnt_total_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DBL_WIDTH-1:0] dt_q;
    logic [DBL_WIDTH-1:0] x_q;
    logic [DBL_WIDTH-1:0] y_q;
    logic [DBL_WIDTH-1:0] q_q;
    logic [DBL_WIDTH-1:0] result_q;
    logic                 rd_en_q;
    logic                 wr_en_q;
    logic                 done_q;
    logic                 valid_q;
    logic                 err_q;
    logic                 wd_expire;
    logic [IDX_W:0]       n_clamped_d;
    logic [IDX_W:0]       idx_next_d;

    assign n_clamped_d = (n_elem > MAX_CNT) ? MAX_CNT : n_elem;
    assign idx_next_d  = {1'b0, idx_q} + (IDX_W+1)'(1);

    cmu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == LOAD),
        .en     (state_q == ISSUE),
        .expire (wd_expire)
    );

    // Strobes are set on the transition into their state, so each output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_total_q <= '0;
            idx_q       <= '0;
            dt_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            q_q         <= '0;
            result_q    <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dt_q        <= delta_t;
                        cnt_total_q <= n_clamped_d;
                        idx_q       <= '0;
                        err_q       <= 1'b0;
                        if (n_clamped_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    x_q     <= rd_theta_a;
                    y_q     <= rd_theta_b;
                    q_q     <= rd_q;
                    valid_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    // A finish in the expiry cycle still counts as a completion.
                    if (cmu_finish) begin
                        result_q <= cmu_result;
                        valid_q  <= 1'b0;
                        wr_en_q  <= 1'b1;
                        state_q  <= WRITE;
                    end else if (wd_expire) begin
                        err_q   <= 1'b1;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WRITE: begin
                    idx_q <= idx_next_d[IDX_W-1:0];
                    if (idx_next_d == cnt_total_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rd_en_q <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_timeout = err_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = idx_q;
    assign cmu_valid   = valid_q;
    assign cmu_x       = x_q;
    assign cmu_y       = y_q;
    assign cmu_q       = q_q;
    assign cmu_dt      = dt_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = idx_q;
    assign wr_data     = result_q;

endmodule

// File: tb/tb_cmu_phi_sequencer.sv
// Bench for cmu_phi_sequencer: operand-file and CMU stubs, a write scoreboard,
// a table of whole passes, and hand sequences for stray inputs and mid-pass reset.
`timescale 1ns/1ps
module tb_cmu_phi_sequencer;
    import kalman_seq_pkg::*;

    localparam int TO = 8;
    localparam int NE = 16;
    localparam int IW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [IW:0]   n_elem;
    logic [63:0]   delta_t;
    logic          busy, done, err_timeout, rd_en, cmu_valid, wr_en;
    logic [IW-1:0] rd_addr, wr_addr;
    logic [63:0]   rd_theta_a, rd_theta_b, rd_q;
    logic [63:0]   cmu_x, cmu_y, cmu_q, cmu_dt, cmu_result, wr_data;
    logic          cmu_finish;

    cmu_phi_sequencer #(
        .DBL_WIDTH (64),
        .N_ELEM    (NE),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_elem     (n_elem),
        .delta_t    (delta_t),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_theta_a (rd_theta_a),
        .rd_theta_b (rd_theta_b),
        .rd_q       (rd_q),
        .cmu_valid  (cmu_valid),
        .cmu_x      (cmu_x),
        .cmu_y      (cmu_y),
        .cmu_q      (cmu_q),
        .cmu_dt     (cmu_dt),
        .cmu_finish (cmu_finish),
        .cmu_result (cmu_result),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] cmu_func(input logic [63:0] x, input logic [63:0] y,
                                             input logic [63:0] q, input logic [63:0] dt);
        real r;
        r = ($bitstoreal(x) + $bitstoreal(q)) + $bitstoreal(dt) * $bitstoreal(y);
        return $realtobits(r);
    endfunction

    // Operand register file and CMU stub
    logic [63:0]   ta [NE];
    logic [63:0]   tb [NE];
    logic [63:0]   qq [NE];
    logic          rd_pend = 1'b0;
    logic [IW-1:0] rd_pend_addr = '0;
    int            lat_cfg = 1;
    int            iss_cnt = 0;
    int            stray_mode = 0;

    always @(negedge clk) begin
        if (rd_pend) begin
            rd_theta_a = ta[rd_pend_addr];
            rd_theta_b = tb[rd_pend_addr];
            rd_q       = qq[rd_pend_addr];
        end else begin
            rd_theta_a = 64'hDEAD_BEEF_0000_0001;
            rd_theta_b = 64'hDEAD_BEEF_0000_0002;
            rd_q       = 64'hDEAD_BEEF_0000_0003;
        end
        rd_pend      = rd_en;
        rd_pend_addr = rd_addr;
        cmu_finish = 1'b0;
        cmu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        if (cmu_valid) begin
            iss_cnt++;
            if (lat_cfg != 0 && iss_cnt == lat_cfg) begin
                cmu_finish = 1'b1;
                cmu_result = cmu_func(cmu_x, cmu_y, cmu_q, cmu_dt);
            end
        end else begin
            iss_cnt = 0;
        end
        if ((stray_mode == 1 && !busy) || (stray_mode == 2 && rd_en)) begin
            cmu_finish = 1'b1;
            cmu_result = 64'h7FF8_0000_0000_0000;
            stray_mode = 0;
        end
    end

    // Write scoreboard and event monitor
    typedef struct {
        logic [IW-1:0] addr;
        logic [63:0]   data;
    } exp_t;
    exp_t exp_q[$];

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          done_at = 0;
    logic        valid_at_done = 1'b0;
    logic [63:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (wr_en) begin
            exp_t e;
            wr_cnt++;
            last_wr_data = wr_data;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {60'd0, wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {60'd0, wr_addr}, {60'd0, e.addr});
                chk("wr_data", wr_data, e.data);
            end
        end
        if (done) begin
            done_cnt++;
            done_at = cyc;
            valid_at_done = cmu_valid;
        end
        if (rd_en) rd_cnt++;
    end

    typedef struct {
        int          n;
        int          lat;
        logic [63:0] dt;
        int          exp_done;
        int          exp_wr;
        int          exp_err;
    } vec_t;

    int start_c;

    task automatic pulse_start(input int n, input logic [63:0] dt);
        @(negedge clk);
        start   = 1'b1;
        n_elem  = n[IW:0];
        delta_t = dt;
        start_c = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input int n, input logic [63:0] dt);
        int n_cl;
        exp_t e;
        n_cl = (n > NE) ? NE : n;
        for (int i = 0; i < n_cl; i++) begin
            e.addr = i[IW-1:0];
            e.data = cmu_func(ta[i], tb[i], qq[i], dt);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int d0, output bit got);
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(posedge clk);
            #1;
            if (done_cnt != d0) got = 1'b1;
        end
    endtask

    task automatic run_pass(input vec_t v);
        int d0, w0, r0;
        bit got;
        lat_cfg = v.lat;
        if (v.exp_err == 0) push_exp(v.n, v.dt);
        d0 = done_cnt;
        w0 = wr_cnt;
        r0 = rd_cnt;
        pulse_start(v.n, v.dt);
        wait_done(d0, got);
        @(posedge clk);
        #1;
        chk("done_seen", {63'd0, got}, 64'd1);
        if (v.exp_done >= 0) chk("done_cycle", 64'(done_at - start_c), 64'(v.exp_done));
        chk("write_count", 64'(wr_cnt - w0), 64'(v.exp_wr));
        chk("err_timeout", {63'd0, err_timeout}, 64'(v.exp_err));
        chk("busy_after", {63'd0, busy}, 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        if (v.exp_err != 0) chk("valid_in_done", {63'd0, valid_at_done}, 64'd0);
        if (v.n == 0) chk("no_reads", 64'(rd_cnt - r0), 64'd0);
        $display("pass n=%0d lat=%0d done@%0d writes=%0d err=%0b",
                 v.n, v.lat, done_at - start_c, wr_cnt - w0, err_timeout);
        exp_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        bit got;
        int d0, w0;

        for (int i = 0; i < NE; i++) begin
            ta[i] = $realtobits(1.0 + real'(i));
            tb[i] = $realtobits(2.0 + 0.5 * real'(i));
            qq[i] = $realtobits(0.5 + 0.125 * real'(i));
        end
        vecs[0] = '{n: 1,  lat: 4, dt: QUARTER, exp_done: 8,  exp_wr: 1,  exp_err: 0};
        vecs[1] = '{n: 16, lat: 1, dt: HALF,    exp_done: 65, exp_wr: 16, exp_err: 0};
        vecs[2] = '{n: 0,  lat: 1, dt: ONE,     exp_done: 1,  exp_wr: 0,  exp_err: 0};
        vecs[3] = '{n: 31, lat: 1, dt: TWO,     exp_done: 65, exp_wr: 16, exp_err: 0};
        vecs[4] = '{n: 3,  lat: TO, dt: ONE,    exp_done: 34, exp_wr: 3,  exp_err: 0};
        vecs[5] = '{n: 2,  lat: 0, dt: ONE,     exp_done: -1, exp_wr: 0,  exp_err: 1};
        vecs[6] = '{n: 1,  lat: 2, dt: QUARTER, exp_done: 6,  exp_wr: 1,  exp_err: 0};

        rst_n   = 1'b0;
        start   = 1'b0;
        n_elem  = '0;
        delta_t = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err_timeout}, 64'd0);
        chk("rst_strobes", {61'd0, rd_en, wr_en, cmu_valid}, 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_pass(vecs[i]);
            if (i == 0) chk("first_result_2p0", last_wr_data, TWO);
        end

        // Stray finish in IDLE, then in FETCH; start re-pulsed during ISSUE.
        w0 = wr_cnt;
        d0 = done_cnt;
        stray_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_idle_writes", 64'(wr_cnt - w0), 64'd0);
        chk("stray_idle_busy", {63'd0, busy}, 64'd0);
        stray_mode = 2;
        lat_cfg = 4;
        push_exp(2, ONE);
        pulse_start(2, ONE);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(posedge clk);
            #1;
            if (cmu_valid) got = 1'b1;
        end
        chk("issue_reached", {63'd0, got}, 64'd1);
        @(negedge clk);
        start  = 1'b1;
        n_elem = 5'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, got);
        chk("ign_done_seen", {63'd0, got}, 64'd1);
        chk("ign_done_cycle", 64'(done_at - start_c), 64'd15);
        repeat (5) @(posedge clk);
        #1;
        chk("ign_write_count", 64'(wr_cnt - w0), 64'd2);
        chk("ign_no_restart", {63'd0, busy}, 64'd0);
        chk("ign_single_done", 64'(done_cnt - d0), 64'd1);
        chk("ign_scoreboard", 64'(exp_q.size()), 64'd0);
        $display("seq stray/start-ignore writes=%0d dones=%0d", wr_cnt - w0, done_cnt - d0);
        exp_q.delete();

        // Asynchronous reset while element 3 is in ISSUE.
        w0 = wr_cnt;
        d0 = done_cnt;
        lat_cfg = 4;
        push_exp(8, HALF);
        pulse_start(8, HALF);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk);
            #1;
            if (cmu_valid && rd_addr == 4'd3) got = 1'b1;
        end
        chk("elem3_issue", {63'd0, got}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_strobes", {60'd0, rd_en, wr_en, cmu_valid, done}, 64'd0);
        chk("mid_rst_addr", {56'd0, rd_addr, wr_addr}, 64'd0);
        chk("mid_rst_cmu_x", cmu_x, 64'd0);
        chk("mid_rst_cmu_dt", cmu_dt, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_writes", 64'(wr_cnt - w0), 64'd3);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        $display("seq mid-pass reset writes=%0d dones=%0d", wr_cnt - w0, done_cnt - d0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_pass('{n: 2, lat: 1, dt: HALF, exp_done: 9, exp_wr: 2, exp_err: 0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
